divide_seq: RTL

DIVIDE_SEQ -- requirements
Module: divide_seq

---
 rtl/divide_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/divide_seq.sv
// Sequential signed fixed-point divider: restoring division, one quotient bit per cycle,
// with round-toward-zero, saturation, divide-by-zero handling and a valid/ready handshake.
module divide_seq #(
    parameter int Q_BITS    = 10,
    parameter int D_WIDTH   = 32,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [D_WIDTH-1:0]   dividend,
    input  logic [D_WIDTH-1:0]   divisor,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [D_WIDTH-1:0]   quotient,
    output logic                 div_by_zero,
    output logic                 overflow,
    output logic [TAG_WIDTH-1:0] tag_out
);

    localparam int N  = D_WIDTH + Q_BITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]      L_LAST    = CW'(N);
    localparam logic [CW-1:0]      L_CNT_ONE = CW'(1);
    localparam logic [N-1:0]       L_ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]       L_NEG_LIM = L_ONE << (D_WIDTH - 1);
    localparam logic [N-1:0]       L_POS_LIM = L_NEG_LIM - L_ONE;
    localparam logic [D_WIDTH-1:0] L_MAX     = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0] L_MIN     = {1'b1, {(D_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_cnt;
    logic [N-1:0]           r_num;
    logic [N-1:0]           r_q;
    logic [D_WIDTH-1:0]     r_rem;
    logic [D_WIDTH-1:0]     r_div;
    logic                   r_sign;
    logic                   r_zero_div;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [D_WIDTH-1:0]     r_quotient;
    logic                   r_div_by_zero;
    logic                   r_overflow;
    logic [TAG_WIDTH-1:0]   r_tag_out;

    // Magnitudes are held unsigned so the most negative operand maps to 2^(D_WIDTH-1).
    logic [D_WIDTH-1:0]     w_dd_mag;
    logic [D_WIDTH-1:0]     w_ds_mag;
    logic [D_WIDTH:0]       w_trial;
    logic [D_WIDTH:0]       w_diff;
    logic                   w_fits;
    logic [D_WIDTH-1:0]     w_fin_q;
    logic                   w_fin_ovf;

    assign w_dd_mag = dividend[D_WIDTH-1] ? -dividend : dividend;
    assign w_ds_mag = divisor[D_WIDTH-1]  ? -divisor  : divisor;
    assign w_trial  = {r_rem, r_num[N-1]};
    assign w_diff   = w_trial - {1'b0, r_div};
    assign w_fits   = ~w_diff[D_WIDTH];

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_fin_q   = r_q[D_WIDTH-1:0];
        w_fin_ovf = 1'b0;
        if (r_zero_div) begin
            w_fin_q = r_sign ? L_MIN : L_MAX;
        end else if (r_sign) begin
            if (r_q > L_NEG_LIM) begin
                w_fin_q   = L_MIN;
                w_fin_ovf = 1'b1;
            end else begin
                w_fin_q = -r_q[D_WIDTH-1:0];
            end
        end else if (r_q > L_POS_LIM) begin
            w_fin_q   = L_MAX;
            w_fin_ovf = 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (valid_in)        w_next = CALC;
            CALC:    if (r_cnt == L_LAST) w_next = DONE;
            DONE:    if (ready_out)       w_next = IDLE;
            default:                      w_next = IDLE;
        endcase
    end

    always_comb begin
        ready_in  = (r_state == IDLE);
        valid_out = (r_state == DONE);
    end

    // A zero divisor preloads the counter so CALC finalizes on the very next edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt         <= '0;
            r_num         <= '0;
            r_q           <= '0;
            r_rem         <= '0;
            r_div         <= '0;
            r_sign        <= 1'b0;
            r_zero_div    <= 1'b0;
            r_tag         <= '0;
            r_quotient    <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
            r_tag_out     <= '0;
        end else begin
            case (r_state)
                IDLE: if (valid_in) begin
                    r_num      <= {w_dd_mag, {Q_BITS{1'b0}}};
                    r_div      <= w_ds_mag;
                    r_rem      <= '0;
                    r_q        <= '0;
                    r_sign     <= dividend[D_WIDTH-1] ^ divisor[D_WIDTH-1];
                    r_zero_div <= (divisor == '0);
                    r_tag      <= tag_in;
                    r_cnt      <= (divisor == '0) ? L_LAST : '0;
                end
                CALC: if (r_cnt != L_LAST) begin
                    r_rem <= w_fits ? w_diff[D_WIDTH-1:0] : w_trial[D_WIDTH-1:0];
                    r_q   <= {r_q[N-2:0], w_fits};
                    r_num <= {r_num[N-2:0], 1'b0};
                    r_cnt <= r_cnt + L_CNT_ONE;
                end else begin
                    r_quotient    <= w_fin_q;
                    r_overflow    <= w_fin_ovf;
                    r_div_by_zero <= r_zero_div;
                    r_tag_out     <= r_tag;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;
    assign tag_out     = r_tag_out;

endmodule
